// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline hazard controller with multi-cycle hold FSM
//
// Purpose: sequences Fetch and the D/E/M pipeline registers. It does four jobs:
//   - resolves load-use hazards by stalling F/D and flushing E;
//   - drains PC-writing instructions through ResultW;
//   - flushes on branches taken in E;
//   - holds E for multi-cycle SIMD ops.
// It also selects E-stage forwarding sources and counts stalled fetch cycles.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   RA1D, RA2D                 Decode source registers
//   RA1E, RA2E                 Execute source registers
//   WA3E, WA3M, WA3W           destination registers in E/M/W
//   RegWriteE/M/W              destination write enables in E/M/W
//   MemtoRegE                  E instruction is a load
//   MultiCycleE                E instruction is a multi-cycle SIMD op
//   PCSrcD/E/M/W               stage instruction writes PC via ResultW
//   BranchTakenE               branch resolved taken in E
//   StallF, StallD, StallE     hold PC / F-D register / E register
//   FlushD, FlushE             clear F-D / D-E register to a bubble
//   BubbleM                    clear E-M register to a bubble
//   ForwardAE, ForwardBE       00 reg file, 01 ResultW, 10 ALUResultM
//   StallCnt                   saturating count of cycles with StallF=1

module hazard_sequencer #(
  parameter int MC_CYCLES   = 4,
  parameter int CNT_W       = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             RA1D,
  input  logic [3:0]             RA2D,
  input  logic [3:0]             RA1E,
  input  logic [3:0]             RA2E,
  input  logic [3:0]             WA3E,
  input  logic [3:0]             WA3M,
  input  logic [3:0]             WA3W,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   MemtoRegE,
  input  logic                   MultiCycleE,
  input  logic                   PCSrcD,
  input  logic                   PCSrcE,
  input  logic                   PCSrcM,
  input  logic                   PCSrcW,
  input  logic                   BranchTakenE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   BubbleM,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  // A one-cycle op never needs holding, so the FSM stays in IDLE.
  localparam logic             MC_EN    = (MC_CYCLES > 1);
  // The cycle that enters BUSY already counts as the first held cycle.
  localparam logic [CNT_W-1:0] CNT_INIT = (MC_CYCLES > 1) ? CNT_W'(MC_CYCLES - 2) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mc_hold;
  logic             ld_stall, pc_pend, br_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_hold   = 1'b0;
    case (state)
      IDLE: begin
        mc_hold = MultiCycleE & MC_EN;
        if (mc_hold) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        mc_hold = (cnt != '0);
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          // Release cycle: the op completes and E may advance.
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ld_stall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D)) & ~mc_hold;
  assign pc_pend  = PCSrcD | PCSrcE | PCSrcM;
  // A taken branch is only acted on once the E op is allowed to complete.
  assign br_flush = BranchTakenE & ~mc_hold;

  // Controls are gated by reset so they drop asynchronously along with the FSM.
  assign StallF  = reset & (ld_stall | pc_pend | mc_hold);
  assign StallD  = reset & (ld_stall | mc_hold);
  assign StallE  = reset & mc_hold;
  assign FlushD  = reset & (pc_pend | PCSrcW | br_flush);
  assign FlushE  = reset & (ld_stall | br_flush);
  assign BubbleM = reset & mc_hold;

  // M has priority over W because it holds the younger result.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (WA3M == RA1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (WA3W == RA1E)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (WA3M == RA2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (WA3W == RA2E)) ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
    end else if (StallF && (StallCnt != {STALL_CNT_W{1'b1}})) begin
      StallCnt <= StallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - randomized self-checking bench for hazard_sequencer

module tb_hazard_sequencer;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiCycleE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: position of the current multi-cycle op inside E
  // (-1 when no op is being held) and the expected stall count.
  int m_age;
  int m_cnt;
  logic e_sf, e_sd, e_se, e_fd, e_fe, e_bm;
  logic [1:0] e_fa, e_fb;
  logic o_sf, o_sd, o_se, o_fd, o_fe, o_bm;
  logic [1:0] o_fa, o_fb;

  hazard_sequencer #(.MC_CYCLES(MC), .CNT_W(3), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MultiCycleE(MultiCycleE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MultiCycleE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
  endtask

  // One cycle: outputs compared against the model at the falling edge, model
  // advanced at the rising edge. Inputs are expected to be stable from #1
  // after the previous rising edge.
  task automatic step();
    logic start, hold, ld, pend, brf;
    @(negedge clk);
    start = (m_age < 0) && MultiCycleE && (MC > 1);
    hold  = start || (m_age >= 0 && m_age < MC - 1);
    ld    = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D) && !hold;
    pend  = PCSrcD || PCSrcE || PCSrcM;
    brf   = BranchTakenE && !hold;
    e_sf = ld | pend | hold;  e_sd = ld | hold;   e_se = hold;
    e_fd = pend | PCSrcW | brf; e_fe = ld | brf;  e_bm = hold;
    e_fa = fwd(RA1E); e_fb = fwd(RA2E);
    o_sf = StallF; o_sd = StallD; o_se = StallE; o_fd = FlushD; o_fe = FlushE;
    o_bm = BubbleM; o_fa = ForwardAE; o_fb = ForwardBE;
    check("StallF", o_sf, e_sf);   check("StallD", o_sd, e_sd);
    check("StallE", o_se, e_se);   check("FlushD", o_fd, e_fd);
    check("FlushE", o_fe, e_fe);   check("BubbleM", o_bm, e_bm);
    check("ForwardAE", o_fa, e_fa); check("ForwardBE", o_fb, e_fb);
    check("StallCnt", StallCnt, m_cnt);
    @(posedge clk);
    if (m_age >= 0) m_age = (m_age == MC - 1) ? -1 : m_age + 1;
    else if (start) m_age = 1;
    if (e_sf && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_age = -1; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    m_age = -1; m_cnt = 0;
    // Stall/hold requests during reset must be masked.
    PCSrcD = 1; MultiCycleE = 1; BranchTakenE = 1;
    @(negedge clk);
    check("rst_StallF", StallF, 0); check("rst_StallE", StallE, 0);
    check("rst_FlushD", FlushD, 0); check("rst_FlushE", FlushE, 0);
    check("rst_BubbleM", BubbleM, 0); check("rst_StallCnt", StallCnt, 0);
    clear_inputs();
    do_reset();

    // Multi-cycle op held for its full duration.
    MultiCycleE = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mc_StallF", o_sf, i < 3); check("mc_StallD", o_sd, i < 3);
      check("mc_StallE", o_se, i < 3); check("mc_BubbleM", o_bm, i < 3);
    end
    step();  // a new op is accepted immediately, showing IDLE was reached
    check("mc_reentry", o_se, 1);
    MultiCycleE = 0;
    repeat (3) step();

    // Load-use hazard.
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd3; RA2D = 4'd3; RA1D = 4'd7;
    step();
    check("ld_StallF", o_sf, 1); check("ld_StallD", o_sd, 1); check("ld_FlushE", o_fe, 1);
    RA2D = 4'd4; RA1D = 4'd5;
    step();
    check("ld_none_StallF", o_sf, 0); check("ld_none_FlushE", o_fe, 0);
    clear_inputs();

    // Taken branch, in IDLE and then while a multi-cycle op is held.
    BranchTakenE = 1;
    step();
    check("br_FlushD", o_fd, 1); check("br_FlushE", o_fe, 1);
    MultiCycleE = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("brmc_FlushD", o_fd, i == 3); check("brmc_FlushE", o_fe, i == 3);
      MultiCycleE = 0;
    end
    clear_inputs();

    // PC write moving down the pipe.
    for (int i = 0; i < 5; i++) begin
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3);
      step();
      check("pc_StallF", o_sf, i < 3); check("pc_FlushD", o_fd, i < 4);
    end
    clear_inputs();

    // Forwarding priority.
    RA1E = 4'd5; WA3M = 4'd5; WA3W = 4'd5; RegWriteM = 1; RegWriteW = 1;
    step(); check("fwd_M", o_fa, 2'b10);
    RegWriteM = 0;
    step(); check("fwd_W", o_fa, 2'b01);
    RegWriteW = 0;
    step(); check("fwd_none", o_fa, 2'b00);
    clear_inputs();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      MultiCycleE  = ($urandom_range(0, 5) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 3) == 0);
      step();
    end
    clear_inputs();

    // Asynchronous reset in the middle of a held op.
    do_reset();
    MultiCycleE = 1;
    step();
    MultiCycleE = 0;
    @(negedge clk);
    check("busy_StallE", StallE, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_StallF", StallF, 0); check("arst_StallE", StallE, 0);
    check("arst_BubbleM", BubbleM, 0); check("arst_StallCnt", StallCnt, 0);
    m_age = -1; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    step();
    check("arst_idle", o_se, 0);

    // Stall counter saturation.
    do_reset();
    PCSrcD = 1;
    repeat (65534) step();
    @(negedge clk);
    check("cnt_below_sat", StallCnt, 16'hFFFE);
    @(posedge clk); #1;
    m_cnt++;
    repeat (5) step();
    @(negedge clk);
    check("cnt_sat", StallCnt, 16'hFFFF);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
